// File: rtl/dual_ram_pkg.sv
// Shared types and default sizing for the dual-RAM write arbiter.
package dual_ram_pkg;

    localparam int DEF_N  = 32;
    localparam int DEF_B  = 8;
    localparam int DEF_R  = 4;
    localparam int DEF_LW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/dual_ram_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, modulo R.
module rr_pick #(
    parameter int R  = 4,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          valid
);

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        winner = {PW{1'b0}};
        valid  = |req;
        for (int k = R - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % R]) begin
                winner = PW'((int'(ptr) + k) % R);
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/dual_ram_wr_arbiter.sv
// Round-robin burst arbiter feeding the write port of dual_ram.
// Bursts run to completion; one arbitration cycle separates consecutive bursts.
module dual_ram_wr_arbiter
    import dual_ram_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int Add = $clog2(N),
    parameter int B   = DEF_B,
    parameter int R   = DEF_R,
    parameter int LW  = DEF_LW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]     req,
    input  logic [R*Add-1:0] req_addr,
    input  logic [R*LW-1:0]  req_len,
    input  logic [R*B-1:0]   wdata,
    output logic [R-1:0]     gnt,
    output logic [R-1:0]     ack,
    output logic             done,
    output logic             busy,
    output logic             ram_wr,
    output logic [Add-1:0]   ram_addr,
    output logic [B-1:0]     ram_din
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    state_t          state_r;
    state_t          next_state_s;
    logic [R-1:0]    gnt_r;
    logic [PW-1:0]   gnt_idx_r;
    logic [PW-1:0]   ptr_r;
    logic [Add-1:0]  cur_addr_r;
    logic [LW-1:0]   cnt_r;
    logic [PW-1:0]   win_s;
    logic            win_valid_s;
    logic            last_beat_s;

    rr_pick #(.R(R), .PW(PW)) u_rr_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (win_s),
        .valid  (win_valid_s)
    );

    assign last_beat_s = (state_r == BURST) && (cnt_r == {LW{1'b0}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    next_state_s = BURST;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BURST: begin
                if (cnt_r == {LW{1'b0}}) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BURST;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Grant, pointer and burst address/count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r      <= {R{1'b0}};
            gnt_idx_r  <= {PW{1'b0}};
            ptr_r      <= {PW{1'b0}};
            cur_addr_r <= {Add{1'b0}};
            cnt_r      <= {LW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        gnt_r      <= {{(R-1){1'b0}}, 1'b1} << win_s;
                        gnt_idx_r  <= win_s;
                        cur_addr_r <= req_addr[int'(win_s)*Add +: Add];
                        cnt_r      <= req_len[int'(win_s)*LW +: LW];
                        ptr_r      <= (win_s == PW'(R - 1)) ? {PW{1'b0}} : win_s + PW'(1);
                    end
                end
                BURST: begin
                    // Explicit compare keeps the wrap correct when N is not a power of two.
                    cur_addr_r <= (cur_addr_r == Add'(N - 1)) ? {Add{1'b0}} : cur_addr_r + Add'(1);
                    if (cnt_r == {LW{1'b0}}) begin
                        gnt_r <= {R{1'b0}};
                    end else begin
                        cnt_r <= cnt_r - LW'(1);
                    end
                end
                default: begin
                    gnt_r <= {R{1'b0}};
                end
            endcase
        end
    end

    // Output decode from registered state; only the data mux sees live wdata.
    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = {Add{1'b0}};
        ram_din  = {B{1'b0}};
        ack      = {R{1'b0}};
        if (state_r == BURST) begin
            ram_wr   = 1'b1;
            ram_addr = cur_addr_r;
            ram_din  = wdata[int'(gnt_idx_r)*B +: B];
            ack      = gnt_r;
        end else begin
            ram_wr   = 1'b0;
            ram_addr = {Add{1'b0}};
            ram_din  = {B{1'b0}};
            ack      = {R{1'b0}};
        end
    end

    assign gnt  = gnt_r;
    assign busy = (state_r == BURST);
    assign done = last_beat_s;

endmodule
